// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, LSB first, optional parity bit.
// Define RX_MAJORITY_VOTE_EN to decide each bit by a 3-sample majority.
module uart_rx #(
   parameter int RX_Data_Width = 8
) (
   input  logic                     RX_CLK,
   input  logic                     RX_RST,
   input  logic                     RX_IN,
   input  logic [5:0]               Prescale,
   input  logic                     RX_Parity_Enable,
   input  logic                     RX_Parity_Type,
   output logic [RX_Data_Width-1:0] RX_Parallel_Data,
   output logic                     RX_Data_Valid,
   output logic                     RX_Parity_Error,
   output logic                     RX_Stop_Error,
   output logic                     RX_Busy
);
   localparam int BW =
      (RX_Data_Width > 1) ? $clog2(RX_Data_Width) : 1;
   localparam logic [BW-1:0] LAST = BW'(RX_Data_Width - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } state_t;

   state_t                   state_q, state_d;
   logic [1:0]               sync_q;
   logic                     rx_s;
   logic [5:0]               cnt_q, cnt_d;
   logic [BW-1:0]            bcnt_q, bcnt_d;
   logic [5:0]               presc_q, presc_d;
   logic                     pen_q, pen_d;
   logic                     ptype_q, ptype_d;
   logic                     s1_q, s1_d;
   logic                     par_q, par_d;
   logic [RX_Data_Width-1:0] shift_q, shift_d;
   logic [RX_Data_Width-1:0] data_q, data_d;
   logic                     valid_q, valid_d;
   logic                     perr_q, perr_d;
   logic                     serr_q, serr_d;
   logic [5:0]               half;
   logic                     samp_b, decide, wrap;
   logic                     bit_v;
   logic                     exp_par;

   assign rx_s    = sync_q[1];
   assign half    = {1'b0, presc_q[5:1]};
   assign samp_b  = (cnt_q == half);
   assign decide  = (cnt_q == half + 6'd1);
   assign wrap    = (cnt_q == presc_q - 6'd1);
   assign exp_par = (^shift_q) ^ ptype_q;

`ifdef RX_MAJORITY_VOTE_EN
   logic s0_q, s0_d;
   logic samp_a;
   assign samp_a = (cnt_q == half - 6'd1);
   assign bit_v  = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

   // early sample, only used by the majority vote
   always_ff @(posedge RX_CLK or negedge RX_RST) begin
      if (!RX_RST) s0_q <= 1'b1;
      else         s0_q <= s0_d;
   end

   // capture the early sample while a frame is in progress
   always_comb begin
      s0_d = s0_q;
      if (state_q != IDLE && samp_a) s0_d = rx_s;
   end
`else
   assign bit_v = s1_q;
`endif

   // two-flop synchronizer, idles high
   always_ff @(posedge RX_CLK or negedge RX_RST) begin
      if (!RX_RST) sync_q <= 2'b11;
      else         sync_q <= {sync_q[0], RX_IN};
   end

   // FSM, counters, latched config and output pulse registers
   always_ff @(posedge RX_CLK or negedge RX_RST) begin
      if (!RX_RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bcnt_q  <= '0;
         presc_q <= 6'd8;
         pen_q   <= 1'b0;
         ptype_q <= 1'b0;
         s1_q    <= 1'b1;
         par_q   <= 1'b0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         serr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bcnt_q  <= bcnt_d;
         presc_q <= presc_d;
         pen_q   <= pen_d;
         ptype_q <= ptype_d;
         s1_q    <= s1_d;
         par_q   <= par_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         serr_q  <= serr_d;
      end
   end

   // next state: bit timing, decisions and frame outcome
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      bcnt_d  = bcnt_q;
      presc_d = presc_q;
      pen_d   = pen_q;
      ptype_d = ptype_q;
      s1_d    = s1_q;
      par_d   = par_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      perr_d  = 1'b0;
      serr_d  = 1'b0;
      if (state_q != IDLE) begin
         cnt_d = wrap ? 6'd0 : cnt_q + 6'd1;
         if (samp_b) s1_d = rx_s;
      end
      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               presc_d = Prescale;
               pen_d   = RX_Parity_Enable;
               ptype_d = RX_Parity_Type;
            end
         end
         START: begin
            if (decide && bit_v) begin
               state_d = IDLE;
            end else if (wrap) begin
               state_d = DATA;
               bcnt_d  = '0;
            end
         end
         DATA: begin
            if (decide)
               shift_d = {bit_v, shift_q[RX_Data_Width-1:1]};
            if (wrap) begin
               if (bcnt_q == LAST)
                  state_d = pen_q ? PARITY : STOP;
               else
                  bcnt_d = bcnt_q + 1'b1;
            end
         end
         PARITY: begin
            if (decide) par_d = bit_v;
            if (wrap) state_d = STOP;
         end
         STOP: begin
            if (decide) begin
               state_d = IDLE;
               if (!bit_v)
                  serr_d = 1'b1;
               else if (pen_q && (par_q != exp_par))
                  perr_d = 1'b1;
               else begin
                  valid_d = 1'b1;
                  data_d  = shift_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign RX_Parallel_Data = data_q;
   assign RX_Data_Valid    = valid_q;
   assign RX_Parity_Error  = perr_q;
   assign RX_Stop_Error    = serr_q;
   assign RX_Busy          = (state_q != IDLE);
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: UART_RX

Interface
REQ-001 Parameter RX_Data_Width, default 8, data bits per frame.
REQ-002 RX_CLK  in  1  oversampling clock; all state on rising edge.
REQ-003 RX_RST  in  1  reset; one clock, reset asynchronous, active-low.
REQ-004 RX_IN  in  1  serial line; idle high; asynchronous to RX_CLK.
REQ-005 Prescale  in  6  RX_CLK cycles per bit; legal values 8, 16, 32.
REQ-006 RX_Parity_Enable  in  1  1 = frame carries a parity bit.
REQ-007 RX_Parity_Type  in  1  1 = odd, 0 = even.
REQ-008 RX_Parallel_Data  out  RX_Data_Width  last good data word.
REQ-009 RX_Data_Valid  out  1  one-cycle pulse; RX_Parallel_Data updated.
REQ-010 RX_Parity_Error  out  1  one-cycle pulse; parity mismatch.
REQ-011 RX_Stop_Error  out  1  one-cycle pulse; stop bit sampled 0.
REQ-012 RX_Busy  out  1  high from start detection until return to IDLE.

Function
REQ-013 RX_IN shall pass through a 2-flop synchronizer; all decisions shall use the synchronized value (rx_s).
REQ-014 The FSM states shall be IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE -> START on the first edge with rx_s = 0; the bit-cycle counter shall clear to 0 on that edge.
REQ-016 Prescale, RX_Parity_Enable and RX_Parity_Type shall be latched at start detection; changes mid-frame shall be ignored.
REQ-017 Each bit shall last Prescale cycles; the counter shall run 0..Prescale-1 and wrap. Bit value shall be decided at count Prescale/2+1.
REQ-018 START: if the decided value is 1, the FSM shall return to IDLE with no output pulse (glitch reject); otherwise it shall go to DATA at wrap.
REQ-019 DATA: RX_Data_Width bits, LSB first, shifted into an internal register. At wrap after the last bit, go to PARITY if enabled, else STOP.
REQ-020 Expected parity: even = XOR of data bits; odd = its inverse.
REQ-021 STOP: on decision, go to IDLE in the next cycle without waiting for the bit end, so back-to-back frames are accepted.
REQ-022 In the cycle after the stop decision, exactly one of three outcomes shall occur:
  - stop = 0: RX_Stop_Error pulse only, regardless of parity.
  - stop = 1 and parity mismatch: RX_Parity_Error pulse only.
  - otherwise: RX_Data_Valid pulse, with RX_Parallel_Data loaded in the same cycle.
REQ-023 RX_Parallel_Data shall hold its value until the next good frame.
REQ-024 Latency: with N = 2 + RX_Data_Width + parity bits, the output pulse shall occur (N-1)*Prescale + Prescale/2 + 2 cycles after start detection.
REQ-025 RX_Busy shall be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.

Reset
REQ-026 With RX_RST low, regardless of clock, the block shall be in this state:
  - FSM in IDLE; counter, shift register and synchronizer at their idle values (synchronizer = 1).
  - RX_Parallel_Data = 0.
  - RX_Data_Valid, RX_Parity_Error, RX_Stop_Error, RX_Busy = 0.
REQ-027 Reset mid-frame shall abort the frame with no output pulse. After release, the next rx_s = 0 shall be treated as a new start.

Configuration
REQ-028 Macro RX_MAJORITY_VOTE_EN:
  - Defined: each bit value shall be the majority of rx_s at counts Prescale/2-1, Prescale/2 and Prescale/2+1.
  - Undefined: each bit value shall be rx_s at count Prescale/2 alone.
  - Decision timing (REQ-017) and latency (REQ-024) shall be identical in both builds.

Verification
REQ-029 Prescale=8, no parity, frame 0xE7 -> one RX_Data_Valid pulse, RX_Parallel_Data=0xE7, no error pulse, pulse at REQ-024 cycle.
REQ-030 Prescale=16, odd parity, 0xE7 with parity 1, then even parity, 0xE7 with parity 1 -> first: valid 0xE7; second: RX_Parity_Error pulse, no valid, data output still 0xE7.
REQ-031 Prescale=8, 0x55 frame with stop bit 0 -> RX_Stop_Error pulse, no valid; then a correct 0x3C frame -> valid 0x3C.
REQ-032 Idle line, RX_IN low for 2 cycles at Prescale=8 -> FSM returns to IDLE, RX_Busy drops, no pulses.
REQ-033 Even parity, 0xE7 then 0x38 sent back-to-back with a 1-bit-period stop -> two valid pulses, data 0xE7 then 0x38.
REQ-034 RX_RST low at data bit 4 -> all outputs 0 immediately; a full 0xA5 frame after release -> valid 0xA5.
REQ-035 Build with RX_MAJORITY_VOTE_EN: one-cycle inverted glitch at a sample point -> correct data. Build without it: the glitch shall corrupt the data.
